clk_enable_bank: RTL and testbench

Parametrised bank of clock-enable (tick) generators, the successor to the fixed divide-by-100000 enable. Each channel produces a one-cycle `tick` every `div` cycles of `clk`. The divisor is run-time programmable through a valid/ready config port, and each channel runs in periodic or one-shot mode. Sits beside the system clock and feeds slow-rate enables to display multiplexing, debouncing and FP-adder demo sequencing logic.

---
 rtl/clk_enable_pkg.sv | 17 +
 rtl/clk_enable_ch.sv | 91 +++++++++
 rtl/clk_enable_bank.sv | 59 +++++
 tb/tb_clk_enable_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_enable_pkg.sv
// Shared defaults and types for the clock-enable bank and its channels.
package clk_enable_pkg;

    localparam int CNT_W_DEF       = 17;
    localparam int DEFAULT_DIV_DEF = 100000;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] div;
        logic                 oneshot;
    } ch_cfg_t;

    typedef enum logic {
        CH_RUN  = 1'b0,
        CH_HALT = 1'b1
    } ch_state_t;

endpackage

// File: rtl/clk_enable_ch.sv
// One tick channel: counter, active and shadow divisor/mode, and the RUN/HALT one-shot FSM.
module clk_enable_ch
    import clk_enable_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic             cfg_oneshot_i,
    output logic             tick_o,
    output logic             pending_o,
    output logic             halted_o
);

    ch_state_t        state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] div_q;
    logic             oneshot_q;
    logic [CNT_W-1:0] sh_div_q;
    logic             sh_oneshot_q;
    logic             pending_q;
    logic             tick_q;

    logic             running;
    logic [CNT_W-1:0] last_cnt;
    logic             wrap;

    // Divisors 0 and 1 both mean "wrap on every running cycle".
    always_comb begin
        running  = en_i && (state_q == CH_RUN);
        last_cnt = (div_q > CNT_W'(1)) ? (div_q - CNT_W'(1)) : '0;
        wrap     = running && (count_q == last_cnt);
        count_d  = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CH_RUN;
            count_q   <= '0;
            div_q     <= CNT_W'(DEFAULT_DIV);
            oneshot_q <= 1'b0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            if (wr_i) begin
                sh_div_q     <= cfg_div_i;
                sh_oneshot_q <= cfg_oneshot_i;
            end
            if (!running) begin
                count_q <= '0;
                tick_q  <= 1'b0;
                if (wr_i) begin
                    div_q     <= cfg_div_i;
                    oneshot_q <= cfg_oneshot_i;
                    state_q   <= CH_RUN;
                end
            end else if (wrap) begin
                // The finished period used the old divisor; a new config takes over from here.
                count_q <= '0;
                tick_q  <= 1'b1;
                state_q <= oneshot_q ? CH_HALT : CH_RUN;
                if (wr_i) begin
                    div_q     <= cfg_div_i;
                    oneshot_q <= cfg_oneshot_i;
                    state_q   <= CH_RUN;
                end else if (pending_q) begin
                    div_q     <= sh_div_q;
                    oneshot_q <= sh_oneshot_q;
                    pending_q <= 1'b0;
                    state_q   <= CH_RUN;
                end
            end else begin
                count_q <= count_d;
                tick_q  <= 1'b0;
                if (wr_i) begin
                    pending_q <= 1'b1;
                end
            end
        end
    end

    assign tick_o    = tick_q;
    assign pending_o = pending_q;
    assign halted_o  = (state_q == CH_HALT);

endmodule

// File: rtl/clk_enable_bank.sv
// Bank of NUM_CH programmable tick generators sharing one valid/ready config port.
module clk_enable_bank
    import clk_enable_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = CNT_W_DEF,
    parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] halted
);

    logic sel_pending;
    logic accept;

    // Out-of-range channel numbers find no pending bit, so they are accepted and dropped.
    always_comb begin
        sel_pending = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                sel_pending = pending[i];
            end
        end
    end

    assign cfg_ready = !sel_pending && !reset;
    assign accept    = cfg_valid && cfg_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic wr;
        assign wr = accept && (cfg_ch == CH_W'(g));

        clk_enable_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .en_i          (en[g]),
            .wr_i          (wr),
            .cfg_div_i     (cfg_div),
            .cfg_oneshot_i (cfg_oneshot),
            .tick_o        (tick[g]),
            .pending_o     (pending[g]),
            .halted_o      (halted[g])
        );
    end

endmodule

// File: tb/tb_clk_enable_bank.sv
// Bench for clk_enable_bank: vector table, corner-case sequences and a random run against a reference model.
module tb_clk_enable_bank;
    import clk_enable_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 17;
    localparam int DEF = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           cfg_oneshot;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] halted;

    int total = 0;
    int bad   = 0;

    clk_enable_bank #(
        .NUM_CH      (NCH),
        .CNT_W       (DW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .tick        (tick),
        .pending     (pending),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed running cycles per period, active config, FIFO of deferred configs.
    int      m_elapsed [NCH];
    int      m_div     [NCH];
    bit      m_os      [NCH];
    bit      m_halt    [NCH];
    bit      m_tick    [NCH];
    ch_cfg_t m_q       [NCH][$];

    function automatic bit m_ready();
        if (reset) return 1'b0;
        return m_q[int'(cfg_ch)].size() == 0;
    endfunction

    function automatic logic [NCH-1:0] m_vec(input int sel);
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) begin
            case (sel)
                0:       v[i] = m_tick[i];
                1:       v[i] = (m_q[i].size() != 0);
                default: v[i] = m_halt[i];
            endcase
        end
        return v;
    endfunction

    function automatic void m_apply(input int i, input ch_cfg_t c);
        m_div[i]  = int'(c.div);
        m_os[i]   = c.oneshot;
        m_halt[i] = 1'b0;
    endfunction

    function automatic void model_edge();
        bit      acc;
        ch_cfg_t c;
        acc       = cfg_valid && m_ready();
        c.div     = cfg_div;
        c.oneshot = cfg_oneshot;
        for (int i = 0; i < NCH; i++) begin
            bit wr;
            int period;
            wr = acc && (int'(cfg_ch) == i);
            if (reset) begin
                m_elapsed[i] = 0;
                m_div[i]     = DEF;
                m_os[i]      = 1'b0;
                m_halt[i]    = 1'b0;
                m_tick[i]    = 1'b0;
                m_q[i].delete();
            end else if (!en[i] || m_halt[i]) begin
                m_elapsed[i] = 0;
                m_tick[i]    = 1'b0;
                if (wr) m_apply(i, c);
            end else begin
                period       = (m_div[i] < 2) ? 1 : m_div[i];
                m_elapsed[i] = m_elapsed[i] + 1;
                if (m_elapsed[i] >= period) begin
                    m_tick[i]    = 1'b1;
                    m_elapsed[i] = 0;
                    if (wr) m_apply(i, c);
                    else if (m_q[i].size() != 0) m_apply(i, m_q[i].pop_front());
                    else m_halt[i] = m_os[i];
                end else begin
                    m_tick[i] = 1'b0;
                    if (wr) m_q[i].push_back(c);
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs must already be set; checks cfg_ready, clocks one edge, checks registered outputs.
    task automatic edge_chk(input string tag);
        #1;
        chk({tag, ".ready"}, {31'd0, cfg_ready}, {31'd0, m_ready()});
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".tick"},    {28'd0, tick},    {28'd0, m_vec(0)});
        chk({tag, ".pending"}, {28'd0, pending}, {28'd0, m_vec(1)});
        chk({tag, ".halted"},  {28'd0, halted},  {28'd0, m_vec(2)});
    endtask

    task automatic drive(input logic r, input logic [3:0] e, input logic v,
                         input logic [1:0] ch, input int dv, input logic os);
        reset       = r;
        en          = e;
        cfg_valid   = v;
        cfg_ch      = ch;
        cfg_div     = DW'(dv);
        cfg_oneshot = os;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic       cv;
        logic [1:0] ch;
        int         div;
        logic       rdy;
        logic [3:0] tick;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] e, input logic v, input logic [1:0] ch,
                                input int dv, input logic rdy, input logic [3:0] t);
        vec_t x;
        x.rst = r; x.en = e; x.cv = v; x.ch = ch; x.div = dv; x.rdy = rdy; x.tick = t;
        return x;
    endfunction

    vec_t vecs[$];

    initial begin
        drive(1'b1, 4'h0, 1'b0, 2'd0, 0, 1'b0);

        // Reset, then ch0 at the default divisor; then ch3 at divisor 0 and 1.
        vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 2'd0, 0, 1'b0, 4'b0000));
        for (int k = 1; k <= 15; k++)
            vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 2'd0, 0, 1'b1, (k % 5 == 0) ? 4'b0001 : 4'b0000));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 2'd3, 0, 1'b1, 4'b0000));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1'b0, 4'b1000, 1'b0, 2'd3, 0, 1'b1, 4'b1000));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 2'd3, 1, 1'b1, 4'b0000));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(1'b0, 4'b1000, 1'b0, 2'd3, 0, 1'b1, 4'b1000));

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].en, vecs[k].cv, vecs[k].ch, vecs[k].div, 1'b0);
            #1;
            chk($sformatf("vec%0d.rdy", k), {31'd0, cfg_ready}, {31'd0, vecs[k].rdy});
            edge_chk($sformatf("vec%0d", k));
            chk($sformatf("vec%0d.tick_tbl", k), {28'd0, tick}, {28'd0, vecs[k].tick});
        end

        // Deferred divisor change on a running channel.
        drive(1'b1, 4'h0, 1'b0, 2'd0, 0, 1'b0); edge_chk("A.rst");
        drive(1'b0, 4'b0010, 1'b0, 2'd1, 0, 1'b0); edge_chk("A.e1");
        drive(1'b0, 4'b0010, 1'b1, 2'd1, 3, 1'b0); edge_chk("A.e2");
        chk("A.pend_set", {31'd0, pending[1]}, 32'd1);
        cfg_valid = 1'b0;
        #1;
        chk("A.rdy_blocked", {31'd0, cfg_ready}, 32'd0);
        for (int e = 3; e <= 11; e++) begin
            edge_chk("A.run");
            chk("A.tick1", {31'd0, tick[1]}, {31'd0, (e == 5 || e == 8 || e == 11)});
            if (e == 5) chk("A.pend_clr", {31'd0, pending[1]}, 32'd0);
        end

        // One-shot channel, then re-arm by rewriting it.
        drive(1'b0, 4'b0000, 1'b1, 2'd2, 4, 1'b1); edge_chk("B.wr");
        cfg_valid = 1'b0; en = 4'b0100;
        for (int e = 1; e <= 8; e++) begin
            edge_chk("B.run");
            chk("B.tick2", {31'd0, tick[2]},   {31'd0, (e == 4)});
            chk("B.halt2", {31'd0, halted[2]}, {31'd0, (e >= 4)});
        end
        drive(1'b0, 4'b0100, 1'b1, 2'd2, 4, 1'b1); edge_chk("B.rearm");
        chk("B.unhalt", {31'd0, halted[2]}, 32'd0);
        cfg_valid = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            edge_chk("B.run2");
            chk("B.tick2b", {31'd0, tick[2]}, {31'd0, (e == 4)});
        end

        // Enable dropped mid-period restarts the count.
        drive(1'b0, 4'b0000, 1'b0, 2'd0, 0, 1'b0); edge_chk("C.off");
        en = 4'b0001;
        for (int e = 0; e < 3; e++) edge_chk("C.part");
        en = 4'b0000; edge_chk("C.drop");
        en = 4'b0001;
        for (int e = 1; e <= 6; e++) begin
            edge_chk("C.run");
            chk("C.tick0", {31'd0, tick[0]}, {31'd0, (e == 5)});
        end

        // Reset with a pending shadow and a halted channel.
        drive(1'b0, 4'b0000, 1'b1, 2'd2, 2, 1'b1); edge_chk("D.wr2");
        drive(1'b0, 4'b0110, 1'b0, 2'd1, 0, 1'b0); edge_chk("D.e1");
        drive(1'b0, 4'b0110, 1'b1, 2'd1, 7, 1'b0); edge_chk("D.e2");
        cfg_valid = 1'b0;
        chk("D.pend1", {31'd0, pending[1]}, 32'd1);
        chk("D.halt2", {31'd0, halted[2]},  32'd1);
        reset = 1'b1;
        #1;
        chk("D.rdy_rst", {31'd0, cfg_ready}, 32'd0);
        edge_chk("D.rst");
        chk("D.tick0", {28'd0, tick},    32'd0);
        chk("D.pend0", {28'd0, pending}, 32'd0);
        chk("D.halt0", {28'd0, halted},  32'd0);
        drive(1'b0, 4'b0001, 1'b0, 2'd0, 0, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            edge_chk("D.run");
            chk("D.tick_def", {31'd0, tick[0]}, {31'd0, (e == 5)});
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) en = 4'($urandom);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_ch      = 2'($urandom);
            cfg_div     = DW'($urandom_range(0, 7));
            cfg_oneshot = ($urandom_range(0, 3) == 0);
            edge_chk("R");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
